// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the triple-modular-redundancy voter monitor.
package cv32e40p_pkg;

   localparam int NUM_LANES = 3;

   typedef enum logic [1:0] {
      TMR_TRIPLE = 2'd0,
      TMR_DUPLEX = 2'd1,
      TMR_FAIL   = 2'd2
   } tmr_state_e;

endpackage

// File: rtl/cv32e40p_bitwise_majority.sv
// Combinational bitwise 2-of-3 vote with a per-lane disagreement flag.
module cv32e40p_bitwise_majority #(
   parameter int unsigned NBIT = 32
) (
   input  logic [NBIT-1:0] a,
   input  logic [NBIT-1:0] b,
   input  logic [NBIT-1:0] c,
   output logic [NBIT-1:0] maj,
   output logic [2:0]      mis
);

   assign maj    = (a & b) | (a & c) | (b & c);
   assign mis[0] = (a != maj);
   assign mis[1] = (b != maj);
   assign mis[2] = (c != maj);

endmodule

// File: rtl/cv32e40p_tmr_voter_monitor.sv
// TMR voter with lane health tracking: votes three lanes, quarantines a lane
// after THRESH consecutive mismatches and degrades TRIPLE -> DUPLEX -> FAIL.
//
// state      | meaning
// TMR_TRIPLE | all lanes healthy, bitwise majority vote
// TMR_DUPLEX | one lane quarantined, lowest healthy lane wins
// TMR_FAIL   | no trustworthy majority, best-effort vote until clear/reset
module cv32e40p_tmr_voter_monitor
   import cv32e40p_pkg::*;
#(
   parameter int unsigned NBIT   = 32,
   parameter int unsigned THRESH = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   input  logic [NBIT-1:0]      a_i,
   input  logic [NBIT-1:0]      b_i,
   input  logic [NBIT-1:0]      c_i,
   input  logic                 clear_i,
   output logic                 valid_o,
   output logic [NBIT-1:0]      winner_o,
   output logic                 fault_o,
   output logic [2:0]           lane_err_o,
   output logic [2:0]           lane_off_o,
   output logic                 degraded_o,
   output logic                 fail_o,
   output logic [3*CNT_W-1:0]   err_cnt_o
);

   tmr_state_e                              state_q, state_d;
   logic                                    valid_q, valid_d;
   logic [NBIT-1:0]                         winner_q, winner_d;
   logic                                    fault_q, fault_d;
   logic [NUM_LANES-1:0]                    lane_err_q, lane_err_d;
   logic [NUM_LANES-1:0]                    lane_off_q, lane_off_d;
   logic [NUM_LANES-1:0][CNT_W-1:0]         err_cnt_q, err_cnt_d;
   logic [NUM_LANES-1:0][3:0]               cons_q, cons_d;

   logic [NBIT-1:0]      maj;
   logic [2:0]           mis;
   logic                 no_pair;
   logic [NBIT-1:0]      dup_win;
   logic                 dup_diff;
   logic [2:0]           dup_healthy;
   logic [2:0]           reach;
   logic [2:0]           cnt_mis;
   logic [2:0]           cons_upd;

   cv32e40p_bitwise_majority #(
      .NBIT (NBIT)
   ) u_majority (
      .a   (a_i),
      .b   (b_i),
      .c   (c_i),
      .maj (maj),
      .mis (mis)
   );

   assign no_pair = (a_i != b_i) && (a_i != c_i) && (b_i != c_i);

   always_comb begin
      dup_win     = a_i;
      dup_diff    = (a_i != b_i);
      dup_healthy = 3'b011;
      case (lane_off_q)
         3'b001: begin
            dup_win     = b_i;
            dup_diff    = (b_i != c_i);
            dup_healthy = 3'b110;
         end
         3'b010: begin
            dup_win     = a_i;
            dup_diff    = (a_i != c_i);
            dup_healthy = 3'b101;
         end
         default: ;
      endcase
   end

   // A lane is quarantined on the mismatch that would bring its run to THRESH.
   always_comb begin
      reach = 3'b000;
      for (int k = 0; k < NUM_LANES; k++) begin
         reach[k] = mis[k] && (cons_q[k] == 4'(THRESH - 1));
      end
   end

   always_comb begin
      state_d    = state_q;
      valid_d    = 1'b0;
      winner_d   = winner_q;
      fault_d    = 1'b0;
      lane_err_d = lane_err_q;
      lane_off_d = lane_off_q;
      err_cnt_d  = err_cnt_q;
      cons_d     = cons_q;
      cnt_mis    = 3'b000;
      cons_upd   = 3'b000;

      if (clear_i) begin
         state_d    = TMR_TRIPLE;
         lane_err_d = '0;
         lane_off_d = '0;
         err_cnt_d  = '0;
         cons_d     = '0;
         if (valid_i) begin
            valid_d  = 1'b1;
            winner_d = maj;
            fault_d  = |mis;
         end
      end else if (valid_i) begin
         valid_d = 1'b1;
         case (state_q)
            TMR_TRIPLE: begin
               winner_d = maj;
               cnt_mis  = mis;
               cons_upd = 3'b111;
               if (no_pair) begin
                  state_d = TMR_FAIL;
               end else if ((reach & (reach - 3'd1)) != 3'd0) begin
                  state_d = TMR_FAIL;
               end else if (|reach) begin
                  lane_off_d = reach;
                  state_d    = TMR_DUPLEX;
               end
            end
            TMR_DUPLEX: begin
               winner_d = dup_win;
               cons_upd = dup_healthy;
               if (dup_diff) begin
                  cnt_mis = dup_healthy;
                  state_d = TMR_FAIL;
               end
            end
            default: begin
               winner_d = maj;
               cnt_mis  = mis;
               cons_upd = 3'b111;
            end
         endcase
         fault_d = |cnt_mis;

         for (int k = 0; k < NUM_LANES; k++) begin
            if (cons_upd[k]) begin
               if (!cnt_mis[k]) begin
                  cons_d[k] = 4'd0;
               end else if (cons_q[k] != 4'hF) begin
                  cons_d[k] = cons_q[k] + 4'd1;
               end
            end
            if (cnt_mis[k]) begin
               lane_err_d[k] = 1'b1;
               if (err_cnt_q[k] != {CNT_W{1'b1}}) begin
                  err_cnt_d[k] = err_cnt_q[k] + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= TMR_TRIPLE;
         valid_q    <= 1'b0;
         winner_q   <= '0;
         fault_q    <= 1'b0;
         lane_err_q <= '0;
         lane_off_q <= '0;
         err_cnt_q  <= '0;
         cons_q     <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         winner_q   <= winner_d;
         fault_q    <= fault_d;
         lane_err_q <= lane_err_d;
         lane_off_q <= lane_off_d;
         err_cnt_q  <= err_cnt_d;
         cons_q     <= cons_d;
      end
   end

   assign valid_o    = valid_q;
   assign winner_o   = winner_q;
   assign fault_o    = fault_q;
   assign lane_err_o = lane_err_q;
   assign lane_off_o = lane_off_q;
   assign degraded_o = (state_q == TMR_DUPLEX);
   assign fail_o     = (state_q == TMR_FAIL);
   assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// Directed-vector bench for the TMR voter monitor.
module tb_cv32e40p_tmr_voter_monitor;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic [31:0] a_i, b_i, c_i;
   logic        clear_i;
   logic        valid_o;
   logic [31:0] winner_o;
   logic        fault_o;
   logic [2:0]  lane_err_o;
   logic [2:0]  lane_off_o;
   logic        degraded_o;
   logic        fail_o;
   logic [23:0] err_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        valid;
      logic        clear;
      logic [31:0] a, b, c;
      logic        ev;
      logic [31:0] ew;
      logic        ef;
      logic [2:0]  eerr;
      logic [2:0]  eoff;
      logic        edeg;
      logic        efail;
      logic [23:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   cv32e40p_tmr_voter_monitor #(
      .NBIT   (32),
      .THRESH (4),
      .CNT_W  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .c_i        (c_i),
      .clear_i    (clear_i),
      .valid_o    (valid_o),
      .winner_o   (winner_o),
      .fault_o    (fault_o),
      .lane_err_o (lane_err_o),
      .lane_off_o (lane_off_o),
      .degraded_o (degraded_o),
      .fail_o     (fail_o),
      .err_cnt_o  (err_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [31:0] ew,
                          input logic ef, input logic [2:0] eerr, input logic [2:0] eoff,
                          input logic edeg, input logic efail, input logic [23:0] ecnt);
      chk({tag, " valid_o"},    32'(valid_o),    32'(ev));
      chk({tag, " winner_o"},   winner_o,        ew);
      chk({tag, " fault_o"},    32'(fault_o),    32'(ef));
      chk({tag, " lane_err_o"}, 32'(lane_err_o), 32'(eerr));
      chk({tag, " lane_off_o"}, 32'(lane_off_o), 32'(eoff));
      chk({tag, " degraded_o"}, 32'(degraded_o), 32'(edeg));
      chk({tag, " fail_o"},     32'(fail_o),     32'(efail));
      chk({tag, " err_cnt_o"},  32'(err_cnt_o),  32'(ecnt));
   endtask

   function automatic vec_t mk(input logic v, input logic clr, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c,
                               input logic ev, input logic [31:0] ew, input logic ef,
                               input logic [2:0] eerr, input logic [2:0] eoff,
                               input logic edeg, input logic efail, input logic [23:0] ecnt);
      vec_t r;
      r.valid = v;  r.clear = clr; r.a = a; r.b = b; r.c = c;
      r.ev = ev;    r.ew = ew;     r.ef = ef; r.eerr = eerr; r.eoff = eoff;
      r.edeg = edeg; r.efail = efail; r.ecnt = ecnt;
      return r;
   endfunction

   task automatic drive(input logic v, input logic clr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
      @(negedge clk);
      valid_i = v; clear_i = clr; a_i = a; b_i = b; c_i = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
      a_i = '0; b_i = '0; c_i = '0;
      #2 rst = 1'b1;
      #1;
      chk_all("reset", 1'b0, 32'h0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0);
      @(negedge clk);
      rst = 1'b0;

      // All lanes agree for ten cycles
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,
                           1, 32'hA5A5A5A5, 0, 3'b000, 3'b000, 0, 0, 24'h0));
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 32'h0,
                        0, 32'hA5A5A5A5, 0, 3'b000, 3'b000, 0, 0, 24'h0));
      // Lane 2 stuck at zero until quarantined on the fourth mismatch
      for (int i = 1; i <= 4; i++)
         vecs.push_back(mk(1, 0, 32'hFFFF0000, 32'hFFFF0000, 32'h0,
                           1, 32'hFFFF0000, 1, 3'b100, (i == 4) ? 3'b100 : 3'b000,
                           (i == 4), 0, 24'(i) << 16));
      vecs.push_back(mk(1, 0, 32'hFFFF0000, 32'hFFFF0000, 32'h123,
                        1, 32'hFFFF0000, 0, 3'b100, 3'b100, 1, 0, 24'h040000));
      // Healthy duplex lanes disagree
      vecs.push_back(mk(1, 0, 32'h1, 32'h2, 32'h0,
                        1, 32'h1, 1, 3'b111, 3'b100, 0, 1, 24'h040101));
      vecs.push_back(mk(0, 1, 32'h0, 32'h0, 32'h0,
                        0, 32'h1, 0, 3'b000, 3'b000, 0, 0, 24'h0));
      // Lane 1: three mismatches, one match, three mismatches
      for (int i = 1; i <= 3; i++)
         vecs.push_back(mk(1, 0, 32'h5, 32'h7, 32'h5,
                           1, 32'h5, 1, 3'b010, 3'b000, 0, 0, 24'(i) << 8));
      vecs.push_back(mk(1, 0, 32'h5, 32'h5, 32'h5,
                        1, 32'h5, 0, 3'b010, 3'b000, 0, 0, 24'h000300));
      for (int i = 4; i <= 6; i++)
         vecs.push_back(mk(1, 0, 32'h5, 32'h7, 32'h5,
                           1, 32'h5, 1, 3'b010, 3'b000, 0, 0, 24'(i) << 8));
      // Clear coincident with valid: voted, but nothing counted
      vecs.push_back(mk(1, 1, 32'h1, 32'h1, 32'h2,
                        1, 32'h1, 1, 3'b000, 3'b000, 0, 0, 24'h0));
      vecs.push_back(mk(1, 0, 32'h9, 32'h9, 32'h9,
                        1, 32'h9, 0, 3'b000, 3'b000, 0, 0, 24'h0));
      // No two lanes equal: straight to FAIL
      vecs.push_back(mk(1, 0, 32'h1, 32'h2, 32'h4,
                        1, 32'h0, 1, 3'b111, 3'b000, 0, 1, 24'h010101));

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].clear, vecs[i].a, vecs[i].b, vecs[i].c);
         chk_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].ew, vecs[i].ef,
                 vecs[i].eerr, vecs[i].eoff, vecs[i].edeg, vecs[i].efail, vecs[i].ecnt);
      end

      // Lane 0 counter saturation while in FAIL (starts at 1)
      for (int i = 1; i <= 300; i++) begin
         drive(1, 0, 32'hFF, 32'h0, 32'h0);
         if (i == 253) chk("sat pre", 32'(err_cnt_o), 32'h0101FE);
      end
      chk_all("sat", 1'b1, 32'h0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1, 24'h0101FF);

      // Reset in the middle of a valid stream
      drive(1, 0, 32'h3, 32'h3, 32'h3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_all("midrst", 1'b0, 32'h0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0);
      @(negedge clk);
      rst = 1'b0;
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      chk("post-rst idle valid_o", 32'(valid_o), 32'h0);
      drive(1, 0, 32'h3, 32'h3, 32'h3);
      chk_all("post-rst vote", 1'b1, 32'h3, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
